// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port external RAM arbiter.
// Holds the FSM state encodings, port identifiers and default bus widths.
package mem_arbiter_pkg;

  localparam int AW_DEF = 20;
  localparam int DW_DEF = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_req_slot.sv
// Single-entry pending request register for one upstream port.
// A new begin always wins; replacing a slot that was never granted sets the sticky overflow flag.
module mem_req_slot
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          begin_wr,
  input  logic          begin_rd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_wr,
  input  logic          grant,
  output logic          valid,
  output logic          is_wr,
  output logic [AW-1:0] slot_addr,
  output logic [DW-1:0] slot_data,
  output logic          overflow
);

  logic capture_s;

  assign capture_s = begin_wr | begin_rd;

  // Capture a new request, clear on grant; a begin on the grant edge refills without overflow.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      valid     <= 1'b0;
      is_wr     <= 1'b0;
      slot_addr <= {AW{1'b0}};
      slot_data <= {DW{1'b0}};
      overflow  <= 1'b0;
    end else begin
      if (capture_s) begin
        valid     <= 1'b1;
        is_wr     <= begin_wr;
        slot_addr <= addr;
        slot_data <= data_wr;
        if (valid && !grant) begin
          overflow <= 1'b1;
        end
      end else if (grant) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external RAM controller between the SPI emulator (port A, priority)
// and the host back-door (port B), with B anti-starvation and a downstream watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int B_MAX_WAIT = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          a_begin_wr,
  input  logic          a_begin_rd,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data_wr,
  output logic          a_finish,
  output logic [DW-1:0] a_data_rd,
  input  logic          b_begin_wr,
  input  logic          b_begin_rd,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data_wr,
  output logic          b_finish,
  output logic [DW-1:0] b_data_rd,
  output logic          m_begin_wr,
  output logic          m_begin_rd,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data_wr,
  input  logic          m_finish,
  input  logic [DW-1:0] m_data_rd,
  output logic [1:0]    overflow,
  output logic          timeout_err
);

  localparam int WW = $clog2(B_MAX_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          a_valid_s, a_is_wr_s, a_ovf_s;
  logic [AW-1:0] a_slot_addr_s;
  logic [DW-1:0] a_slot_data_s;
  logic          b_valid_s, b_is_wr_s, b_ovf_s;
  logic [AW-1:0] b_slot_addr_s;
  logic [DW-1:0] b_slot_data_s;

  logic          grant_a_s, grant_b_s;
  logic          sel_wr_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_data_s;
  logic          rsp_done_s, rsp_to_s;
  logic [DW-1:0] rsp_data_s;

  logic [1:0]    state_r;
  logic          owner_r, op_wr_r;
  logic [WW-1:0] b_wait_r;
  logic [TW-1:0] wd_r;
  logic          m_begin_wr_r, m_begin_rd_r;
  logic [AW-1:0] m_addr_r;
  logic [DW-1:0] m_data_wr_r;
  logic          a_finish_r, b_finish_r;
  logic [DW-1:0] a_data_rd_r, b_data_rd_r;
  logic          timeout_err_r;

  mem_req_slot #(.AW(AW), .DW(DW)) u_slot_a (
    .mclk      (mclk),
    .reset     (reset),
    .begin_wr  (a_begin_wr),
    .begin_rd  (a_begin_rd),
    .addr      (a_addr),
    .data_wr   (a_data_wr),
    .grant     (grant_a_s),
    .valid     (a_valid_s),
    .is_wr     (a_is_wr_s),
    .slot_addr (a_slot_addr_s),
    .slot_data (a_slot_data_s),
    .overflow  (a_ovf_s)
  );

  mem_req_slot #(.AW(AW), .DW(DW)) u_slot_b (
    .mclk      (mclk),
    .reset     (reset),
    .begin_wr  (b_begin_wr),
    .begin_rd  (b_begin_rd),
    .addr      (b_addr),
    .data_wr   (b_data_wr),
    .grant     (grant_b_s),
    .valid     (b_valid_s),
    .is_wr     (b_is_wr_s),
    .slot_addr (b_slot_addr_s),
    .slot_data (b_slot_data_s),
    .overflow  (b_ovf_s)
  );

  // Priority grant: A first unless B has waited long enough to override once.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (state_r == S_IDLE) begin
      if (b_valid_s && (!a_valid_s || (b_wait_r >= WW'(B_MAX_WAIT)))) begin
        grant_b_s = 1'b1;
      end else if (a_valid_s) begin
        grant_a_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
      end
    end else begin
      grant_b_s = 1'b0;
    end
  end

  // Request mux feeding the downstream latches.
  always_comb begin
    sel_wr_s   = a_is_wr_s;
    sel_addr_s = a_slot_addr_s;
    sel_data_s = a_slot_data_s;
    if (grant_b_s) begin
      sel_wr_s   = b_is_wr_s;
      sel_addr_s = b_slot_addr_s;
      sel_data_s = b_slot_data_s;
    end else begin
      sel_wr_s   = a_is_wr_s;
    end
  end

  // Completion detect: downstream finish or watchdog expiry (writes always return all-ones).
  always_comb begin
    rsp_done_s = 1'b0;
    rsp_to_s   = 1'b0;
    rsp_data_s = {DW{1'b1}};
    if (state_r == S_WAIT) begin
      if (m_finish) begin
        rsp_done_s = 1'b1;
        rsp_data_s = op_wr_r ? {DW{1'b1}} : m_data_rd;
      end else if (wd_r <= TW'(1)) begin
        rsp_done_s = 1'b1;
        rsp_to_s   = 1'b1;
      end else begin
        rsp_done_s = 1'b0;
      end
    end else begin
      rsp_done_s = 1'b0;
    end
  end

  // B starvation counter, saturating.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      b_wait_r <= {WW{1'b0}};
    end else if (grant_b_s || !b_valid_s) begin
      b_wait_r <= {WW{1'b0}};
    end else if (b_wait_r != {WW{1'b1}}) begin
      b_wait_r <= b_wait_r + WW'(1);
    end
  end

  // Transaction sequencer; begin/finish pulses are registered so they coincide with ISSUE/RESP.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      owner_r       <= PORT_A;
      op_wr_r       <= 1'b0;
      wd_r          <= {TW{1'b0}};
      m_begin_wr_r  <= 1'b0;
      m_begin_rd_r  <= 1'b0;
      m_addr_r      <= {AW{1'b0}};
      m_data_wr_r   <= {DW{1'b0}};
      a_finish_r    <= 1'b0;
      b_finish_r    <= 1'b0;
      a_data_rd_r   <= {DW{1'b1}};
      b_data_rd_r   <= {DW{1'b1}};
      timeout_err_r <= 1'b0;
    end else begin
      m_begin_wr_r <= 1'b0;
      m_begin_rd_r <= 1'b0;
      a_finish_r   <= 1'b0;
      b_finish_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (grant_a_s || grant_b_s) begin
            owner_r      <= grant_b_s ? PORT_B : PORT_A;
            op_wr_r      <= sel_wr_s;
            m_addr_r     <= sel_addr_s;
            m_data_wr_r  <= sel_data_s;
            m_begin_wr_r <= sel_wr_s;
            m_begin_rd_r <= !sel_wr_s;
            state_r      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_r    <= TW'(TIMEOUT);
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (rsp_done_s) begin
            if (owner_r == PORT_B) begin
              b_data_rd_r <= rsp_data_s;
              b_finish_r  <= 1'b1;
            end else begin
              a_data_rd_r <= rsp_data_s;
              a_finish_r  <= 1'b1;
            end
            if (rsp_to_s) begin
              timeout_err_r <= 1'b1;
            end
            state_r <= S_RESP;
          end else begin
            wd_r <= wd_r - TW'(1);
          end
        end
        S_RESP: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign m_begin_wr  = m_begin_wr_r;
  assign m_begin_rd  = m_begin_rd_r;
  assign m_addr      = m_addr_r;
  assign m_data_wr   = m_data_wr_r;
  assign a_finish    = a_finish_r;
  assign b_finish    = b_finish_r;
  assign a_data_rd   = a_data_rd_r;
  assign b_data_rd   = b_data_rd_r;
  assign overflow    = {b_ovf_s, a_ovf_s};
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized two-port traffic
// checked against a per-address RAM reference and latency/ordering rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 8;

  logic          mclk = 1'b0;
  logic          reset = 1'b1;
  logic          a_begin_wr = 1'b0, a_begin_rd = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data_wr = '0;
  logic          a_finish;
  logic [DW-1:0] a_data_rd;
  logic          b_begin_wr = 1'b0, b_begin_rd = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data_wr = '0;
  logic          b_finish;
  logic [DW-1:0] b_data_rd;
  logic          m_begin_wr, m_begin_rd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data_wr;
  logic          m_finish = 1'b0;
  logic [DW-1:0] m_data_rd = '0;
  logic [1:0]    overflow;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_arbiter dut (
    .mclk(mclk), .reset(reset),
    .a_begin_wr(a_begin_wr), .a_begin_rd(a_begin_rd), .a_addr(a_addr), .a_data_wr(a_data_wr),
    .a_finish(a_finish), .a_data_rd(a_data_rd),
    .b_begin_wr(b_begin_wr), .b_begin_rd(b_begin_rd), .b_addr(b_addr), .b_data_wr(b_data_wr),
    .b_finish(b_finish), .b_data_rd(b_data_rd),
    .m_begin_wr(m_begin_wr), .m_begin_rd(m_begin_rd), .m_addr(m_addr), .m_data_wr(m_data_wr),
    .m_finish(m_finish), .m_data_rd(m_data_rd),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // RAM contents: written bytes, otherwise a fixed address-derived pattern.
  logic [7:0] mem [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] init_pat(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [19:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return init_pat(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [19:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_pat(a);
  endfunction

  logic [19:0] log_addr[$];
  int          log_cyc[$];
  int          lat = 3;
  bit          drop = 1'b0;

  // Downstream RAM model: answers `lat` cycles after m_begin, optionally never for reads.
  initial begin : responder
    int cd;
    logic [7:0] rd_val;
    cd = -1;
    rd_val = 8'h00;
    forever begin
      @(posedge mclk);
      #1;
      m_finish = 1'b0;
      if (cd > 0) cd--;
      if (cd == 0) begin
        m_finish  = 1'b1;
        m_data_rd = rd_val;
        cd = -1;
      end
      if (m_begin_wr || m_begin_rd) begin
        log_addr.push_back(m_addr);
        log_cyc.push_back(cyc);
        if (m_begin_wr) begin
          mem[int'(m_addr)] = m_data_wr;
          rd_val = 8'h00;
        end else begin
          rd_val = mem_rd(m_addr);
        end
        if (!(drop && m_begin_rd)) cd = lat;
      end
    end
  end

  int a_fin = 0, b_fin = 0, b_fin_cyc = 0;
  initial begin : fin_monitor
    forever begin
      @(negedge mclk);
      if (a_finish) a_fin++;
      if (b_finish) begin
        b_fin++;
        b_fin_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic a_req(input bit wr, input logic [19:0] ad, input logic [7:0] d);
    a_begin_wr = wr; a_begin_rd = !wr; a_addr = ad; a_data_wr = d;
    tick(1);
    a_begin_wr = 1'b0; a_begin_rd = 1'b0;
  endtask

  task automatic b_req(input bit wr, input logic [19:0] ad, input logic [7:0] d);
    b_begin_wr = wr; b_begin_rd = !wr; b_addr = ad; b_data_wr = d;
    tick(1);
    b_begin_wr = 1'b0; b_begin_rd = 1'b0;
  endtask

  task automatic wait_counts(input string tag, input int ta, input int tb, input int maxc);
    int i;
    i = 0;
    while ((a_fin < ta || b_fin < tb) && i < maxc) begin
      tick(1);
      i++;
    end
    check_val(tag, 32'((a_fin >= ta) && (b_fin >= tb)), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_afin"}, a_finish, 0);
    check_val({tag, "_bfin"}, b_finish, 0);
    check_val({tag, "_mbeg"}, {m_begin_wr, m_begin_rd}, 0);
    check_val({tag, "_maddr"}, m_addr, 0);
    check_val({tag, "_mdata"}, m_data_wr, 0);
    check_val({tag, "_ardata"}, a_data_rd, 8'hFF);
    check_val({tag, "_brdata"}, b_data_rd, 8'hFF);
    check_val({tag, "_ovf"}, overflow, 0);
    check_val({tag, "_terr"}, timeout_err, 0);
  endtask

  // One port's random traffic: one outstanding request at a time, disjoint address region per port.
  task automatic port_rand(input bit pb);
    int gap, n;
    bit wr, seen;
    logic [19:0] ad;
    logic [7:0] d, exp;
    string tg;
    for (int i = 0; i < 25; i++) begin
      gap = $urandom_range(0, 4);
      wr  = 1'($urandom_range(0, 1));
      ad  = (pb ? 20'hA0000 : 20'h20000) | 20'($urandom_range(0, 15));
      d   = 8'($urandom);
      tick(gap);
      if (pb) b_req(wr, ad, d);
      else    a_req(wr, ad, d);
      n = 1;
      seen = pb ? b_finish : a_finish;
      while (!seen && n < 400) begin
        tick(1);
        n++;
        seen = pb ? b_finish : a_finish;
      end
      exp = wr ? 8'hFF : ref_rd(ad);
      if (wr) ref_mem[int'(ad)] = d;
      if (pb) begin
        check_val("rand_b_done", 32'(seen), 1);
        check_val("rand_b_data", b_data_rd, exp);
      end else begin
        check_val("rand_a_done", 32'(seen), 1);
        check_val("rand_a_data", a_data_rd, exp);
        tg = "rand_a_latency";
        check_val(tg, 32'(n <= 12), 1);
      end
    end
  endtask

  initial begin : main
    int a0, b0, n0, bbeg, idx;
    do_reset();
    check_reset_outputs("reset");

    // Lone A read: m_begin two cycles after begin, finish one after m_finish.
    mem[32'h12345] = 8'h5A;
    a0 = a_fin; b0 = b_fin;
    a_req(1'b0, 20'h12345, 8'h00);
    check_val("t1_mbeg_early", m_begin_rd, 0);
    tick(1);
    check_val("t1_mbeg", m_begin_rd, 1);
    check_val("t1_maddr", m_addr, 20'h12345);
    tick(1);
    check_val("t1_mbeg_pulse", m_begin_rd, 0);
    tick(2);
    check_val("t1_afin_early", a_finish, 0);
    tick(1);
    check_val("t1_afin", a_finish, 1);
    check_val("t1_adata", a_data_rd, 8'h5A);
    tick(2);
    check_val("t1_afin_cnt", a_fin - a0, 1);
    check_val("t1_bfin_cnt", b_fin - b0, 0);

    // Simultaneous writes: A reaches RAM first.
    n0 = log_addr.size(); a0 = a_fin; b0 = b_fin;
    a_begin_wr = 1'b1; a_addr = 20'h00010; a_data_wr = 8'h11;
    b_begin_wr = 1'b1; b_addr = 20'h80000; b_data_wr = 8'h22;
    tick(1);
    a_begin_wr = 1'b0; b_begin_wr = 1'b0;
    wait_counts("t2_done", a0 + 1, b0 + 1, 60);
    tick(3);
    check_val("t2_nlog", log_addr.size() - n0, 2);
    check_val("t2_first", log_addr[n0], 20'h00010);
    check_val("t2_second", log_addr[n0 + 1], 20'h80000);
    check_val("t2_mem_a", mem_rd(20'h00010), 8'h11);
    check_val("t2_mem_b", mem_rd(20'h80000), 8'h22);
    check_val("t2_afin_cnt", a_fin - a0, 1);
    check_val("t2_bfin_cnt", b_fin - b0, 1);
    check_val("t2_adata", a_data_rd, 8'hFF);

    // Anti-starvation: A begins every cycle while one B read is pending.
    n0 = log_addr.size(); b0 = b_fin; bbeg = 0;
    for (int i = 0; i < 30; i++) begin
      a_begin_rd = 1'b1;
      a_addr = 20'h00100 + 20'(i);
      if (i == 0) begin
        b_begin_rd = 1'b1; b_addr = 20'h80123; bbeg = cyc;
      end
      tick(1);
      b_begin_rd = 1'b0;
    end
    a_begin_rd = 1'b0;
    tick(30);
    idx = -1;
    for (int k = n0; k < log_addr.size(); k++)
      if (idx < 0 && log_addr[k] == 20'h80123) idx = k;
    check_val("t3_b_found", 32'(idx >= 0), 1);
    if (idx < 0) idx = n0;
    check_val("t3_b_pos", idx - n0, 3);
    check_val("t3_b_minwait", 32'((log_cyc[idx] - bbeg) >= 18), 1);
    check_val("t3_b_maxwait", 32'((log_cyc[idx] - bbeg) <= 24), 1);
    check_val("t3_a_next", 32'(log_addr[idx + 1][19]), 0);
    check_val("t3_bfin_cnt", b_fin - b0, 1);
    check_val("t3_ovf", overflow, 2'b01);
    do_reset();
    check_val("t3_ovf_cleared", overflow, 2'b00);

    // Overwrite of a pending A slot while the bus is busy.
    lat = 10;
    n0 = log_addr.size(); a0 = a_fin;
    a_req(1'b0, 20'h01000, 8'h00);
    tick(4);
    a_req(1'b0, 20'h01001, 8'h00);
    check_val("t4_ovf_none", overflow, 2'b00);
    tick(1);
    a_req(1'b0, 20'h01002, 8'h00);
    check_val("t4_ovf", overflow, 2'b01);
    wait_counts("t4_done", a0 + 2, 0, 100);
    tick(5);
    check_val("t4_nlog", log_addr.size() - n0, 2);
    check_val("t4_first", log_addr[n0], 20'h01000);
    check_val("t4_second", log_addr[n0 + 1], 20'h01002);
    check_val("t4_afin_cnt", a_fin - a0, 2);
    tick(20);
    check_val("t4_ovf_sticky", overflow, 2'b01);
    lat = 3;
    do_reset();

    // Watchdog on an unanswered B read, then a normal A read.
    drop = 1'b1;
    n0 = log_addr.size(); b0 = b_fin;
    b_req(1'b0, 20'h90000, 8'h00);
    wait_counts("t5_bdone", 0, b0 + 1, 400);
    drop = 1'b0;
    check_val("t5_delay_lo", 32'((b_fin_cyc - log_cyc[n0]) >= 255), 1);
    check_val("t5_delay_hi", 32'((b_fin_cyc - log_cyc[n0]) <= 257), 1);
    check_val("t5_bdata", b_data_rd, 8'hFF);
    check_val("t5_terr", timeout_err, 1);
    a0 = a_fin;
    a_req(1'b0, 20'h00555, 8'h00);
    wait_counts("t5_adone", a0 + 1, 0, 60);
    check_val("t5_adata", a_data_rd, init_pat(20'h00555));
    check_val("t5_terr_sticky", timeout_err, 1);

    // Reset while waiting on the RAM: the late m_finish must be ignored.
    lat = 8;
    n0 = log_addr.size();
    b_req(1'b0, 20'h80777, 8'h00);
    tick(3);
    check_val("t6_issued", log_addr.size() - n0, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_mid");
    tick(1);
    reset = 1'b0;
    a0 = a_fin; b0 = b_fin;
    tick(15);
    check_val("t6_no_afin", a_fin - a0, 0);
    check_val("t6_no_bfin", b_fin - b0, 0);
    check_val("t6_no_reissue", log_addr.size() - n0, 1);
    lat = 3;
    do_reset();

    // Randomized concurrent traffic on both ports.
    a0 = a_fin; b0 = b_fin;
    fork
      port_rand(1'b0);
      port_rand(1'b1);
    join
    tick(5);
    check_val("rand_afin_cnt", a_fin - a0, 25);
    check_val("rand_bfin_cnt", b_fin - b0, 25);
    check_val("rand_ovf", overflow, 2'b00);
    check_val("rand_terr", timeout_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
